// File: rtl/bip_core_ext.sv
// bip_core_ext: single-cycle accumulator processor with a three-state control FSM.
//
// Purpose: fetches one instruction per enabled cycle from an external combinational
// program memory, executes it against a single accumulator and an external
// combinational-read / clocked-write data RAM, and counts retired instructions.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   enable     in   run/stall control
//   instr      in   program word at address pc (combinational read)
//   ram_rdata  in   data-RAM word at ram_addr (combinational read)
//   pc         out  program counter
//   ram_addr   out  operand field of instr
//   ram_wdata  out  accumulator value to be stored
//   ram_wr     out  write strobe (STO)
//   ram_rd     out  read strobe (LD/ADD/SUB)
//   acc        out  accumulator
//   halted     out  high while in HALT
//   retired    out  retired-instruction count (wraps)
module bip_core_ext #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [DATA_W-1:0]       instr,
    input  logic [DATA_W-1:0]       ram_rdata,
    output logic [DATA_W-5-1:0]     pc,
    output logic [DATA_W-5-1:0]     ram_addr,
    output logic [DATA_W-1:0]       ram_wdata,
    output logic                    ram_wr,
    output logic                    ram_rd,
    output logic [DATA_W-1:0]       acc,
    output logic                    halted,
    output logic [DATA_W-1:0]       retired
);

    localparam int unsigned OPC_W = 5;
    localparam int unsigned OPR_W = DATA_W - OPC_W;

    localparam logic [OPC_W-1:0] OpHlt  = 5'b00000;
    localparam logic [OPC_W-1:0] OpSto  = 5'b00001;
    localparam logic [OPC_W-1:0] OpLd   = 5'b00010;
    localparam logic [OPC_W-1:0] OpLdi  = 5'b00011;
    localparam logic [OPC_W-1:0] OpAdd  = 5'b00100;
    localparam logic [OPC_W-1:0] OpAddi = 5'b00101;
    localparam logic [OPC_W-1:0] OpSub  = 5'b00110;
    localparam logic [OPC_W-1:0] OpSubi = 5'b00111;
    localparam logic [OPC_W-1:0] OpBeq  = 5'b01000;
    localparam logic [OPC_W-1:0] OpBne  = 5'b01001;
    localparam logic [OPC_W-1:0] OpJmp  = 5'b01010;
    localparam logic [OPC_W-1:0] OpBn   = 5'b01011;

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e state_q;

    logic [OPC_W-1:0]  opc;
    logic [OPR_W-1:0]  opr;
    logic [DATA_W-1:0] opr_sx;
    logic [OPR_W-1:0]  pc_inc;
    logic              flag_z;
    logic              flag_n;
    logic              exec;

    always_comb begin
        opc    = instr[DATA_W-1 -: OPC_W];
        opr    = instr[OPR_W-1:0];
        opr_sx = {{OPC_W{opr[OPR_W-1]}}, opr};
        pc_inc = pc + OPR_W'(1);
        // Flags reflect the accumulator before the current instruction executes.
        flag_z = (acc == '0);
        flag_n = acc[DATA_W-1];
        // Reset gating keeps a STO from writing RAM on the reset edge.
        exec   = (state_q == StRun) && enable && !reset;
    end

    always_comb begin
        ram_addr  = opr;
        ram_wdata = acc;
        ram_wr    = exec && (opc == OpSto);
        ram_rd    = exec && ((opc == OpLd) || (opc == OpAdd) || (opc == OpSub));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc      <= '0;
            acc     <= '0;
            retired <= '0;
            halted  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // The transition cycle itself executes nothing.
                    if (enable) state_q <= StRun;
                end
                StRun: begin
                    if (enable) begin
                        retired <= retired + DATA_W'(1);
                        pc      <= pc_inc;
                        case (opc)
                            OpHlt: begin
                                pc      <= pc;
                                state_q <= StHalt;
                                halted  <= 1'b1;
                            end
                            OpLd:   acc <= ram_rdata;
                            OpLdi:  acc <= opr_sx;
                            OpAdd:  acc <= acc + ram_rdata;
                            OpAddi: acc <= acc + opr_sx;
                            OpSub:  acc <= acc - ram_rdata;
                            OpSubi: acc <= acc - opr_sx;
                            OpBeq:  if (flag_z)  pc <= opr;
                            OpBne:  if (!flag_z) pc <= opr;
                            OpJmp:  pc <= opr;
                            OpBn:   if (flag_n)  pc <= opr;
                            default: ;  // STO and unassigned opcodes only advance pc
                        endcase
                    end
                end
                StHalt: ;  // sticky until reset
                default: begin
                    state_q <= StIdle;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule
